// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative HI/LO multiply/divide unit.
//
// Purpose:
//   Implements MULT/MULTU (shift-add, one bit per cycle), DIV/DIVU
//   (restoring, one bit per cycle) and the MTHI/MTLO register writes.
//   Signed operations run on operand magnitudes and fix up signs at the
//   end. Results land in registered hi/lo together with a one-cycle done
//   pulse. err pulses alongside done for divide-by-zero.
//
// Configuration:
//   ALU_MULDIV_DIV_EN - when defined, the iterative divider and the DIV
//                       state are built. When undefined, DIV/DIVU are
//                       accepted but only pulse done+err the next cycle
//                       and leave hi/lo untouched.
//
// Parameters:
//   WIDTH  operand and HI/LO width (>= 8, even), default 32
//   CNT_W  iteration counter width (2**CNT_W > WIDTH), default 6
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high reset
//   in_valid  op/operands valid this cycle
//   in_ready  unit idle and able to accept
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   rsData    operand A (dividend / multiplicand / MTHI-MTLO source)
//   rtData    operand B (divisor / multiplier)
//   hi, lo    registered result registers
//   busy      iterative op in flight
//   done      one-cycle pulse when hi/lo hold a new result
//   err       one-cycle pulse with done on an erroneous op
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH);

`ifdef ALU_MULDIV_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL
    } state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV.
    logic [WIDTH-1:0]   opa;
    // Running {partial product, remaining multiplier bits}.
    logic [2*WIDTH-1:0] prod;
    // Product (MUL) or quotient (DIV) must be negated at the end.
    logic               neg_res;

    logic               accept;
    logic               is_signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_res;

`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   rs_raw;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;
`endif

    // Two's-complement magnitude; unsigned ops pass straight through.
    // The most-negative value maps to 2**(WIDTH-1), which is still exact
    // when read back as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             as_signed);
        if (as_signed && v[WIDTH-1])
            return ~v + ONE_W;
        else
            return v;
    endfunction

    assign in_ready     = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign accept       = in_valid && in_ready && (op <= OP_MTLO);
    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);

    // One shift-add step: add the multiplicand when the low multiplier bit
    // is set, then shift the whole product register right by one. The
    // carry out of the add becomes the new top bit.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        prod_res = neg_res ? (~prod + ONE_2W) : prod;
    end

`ifdef ALU_MULDIV_DIV_EN
    // One restoring-division step: bring the next dividend bit into the
    // remainder, subtract the divisor if it fits, and shift the outcome
    // into the quotient. The remainder stays below the divisor, so a
    // WIDTH-bit subtraction is exact once the compare has passed.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opa});
        rem_next  = div_ge ? (div_shift[WIDTH-1:0] - opa) : div_shift[WIDTH-1:0];
        quo_res   = neg_res ? (~quo + ONE_W) : quo;
        rem_res   = neg_rem ? (~rem + ONE_W) : rem;
    end
`endif

    // Main controller and datapath. done/err default low so they only
    // pulse for a single cycle. The counter runs 0..WIDTH: WIDTH edges
    // of iteration, then one more edge writes hi/lo and returns to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            opa     <= '0;
            prod    <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            rem      <= '0;
            quo      <= '0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            rs_raw   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                opa     <= magnitude(rsData, is_signed_op);
                                prod    <= {{WIDTH{1'b0}}, magnitude(rtData, is_signed_op)};
                                neg_res <= is_signed_op && (rsData[WIDTH-1] ^ rtData[WIDTH-1]);
                                state   <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef ALU_MULDIV_DIV_EN
                                opa      <= magnitude(rtData, is_signed_op);
                                quo      <= magnitude(rsData, is_signed_op);
                                rem      <= '0;
                                neg_res  <= is_signed_op && (rsData[WIDTH-1] ^ rtData[WIDTH-1]);
                                neg_rem  <= is_signed_op && rsData[WIDTH-1];
                                div_zero <= (rtData == '0);
                                rs_raw   <= rsData;
                                state    <= ST_DIV;
`else
                                done <= 1'b1;
                                err  <= 1'b1;
`endif
                            end
                            OP_MTHI: begin
                                hi   <= rsData;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= rsData;
                                done <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                ST_MUL: begin
                    if (cnt == LAST_CNT) begin
                        hi    <= prod_res[2*WIDTH-1:WIDTH];
                        lo    <= prod_res[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        prod <= mul_next;
                        cnt  <= cnt + ONE_CNT;
                    end
                end

`ifdef ALU_MULDIV_DIV_EN
                ST_DIV: begin
                    if (cnt == LAST_CNT) begin
                        // Divide-by-zero still spends the full iteration time
                        // so the latency seen by software does not depend
                        // on the divisor value.
                        if (div_zero) begin
                            hi  <= rs_raw;
                            lo  <= '1;
                            err <= 1'b1;
                        end else begin
                            hi <= rem_res;
                            lo <= quo_res;
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= {quo[WIDTH-2:0], div_ge};
                        cnt <= cnt + ONE_CNT;
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
